// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and issues credit-limited in-order imem requests.
// It buffers responses for decode and drops stale in-flight responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            req_valid_q, req_valid_d;
  logic [31:0]     buf_pc_q    [BUF_DEPTH];
  logic [31:0]     buf_instr_q [BUF_DEPTH];

  logic            req_fire_s;
  logic            resp_fire_s;
  logic            push_s;
  logic            pop_s;
  logic [31:0]     target_s;

  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign req_fire_s  = req_valid_q & imem_req_ready;
  assign resp_fire_s = imem_resp_valid & (outst_q != '0);
  assign push_s      = resp_fire_s & (drop_q == '0) & ~redirect_valid;
  assign pop_s       = (cnt_q != '0) & if_ready & ~redirect_valid;
  assign target_s    = redirect_pc & 32'hFFFF_FFFC;

  // Next-state computation for PCs, counters, buffer pointers and FSM.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    req_valid_d = 1'b0;

    if (req_fire_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    case ({req_fire_s, resp_fire_s})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (resp_fire_s && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end else begin
      drop_d = drop_q;
    end

    if (push_s) begin
      resp_pc_d = resp_pc_q + 32'd4;
      tail_d    = tail_q + PW'(1);
    end else begin
      resp_pc_d = resp_pc_q;
      tail_d    = tail_q;
    end

    if (pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_FETCH: state_d = ST_FETCH;
      ST_FLUSH: begin
        if (drop_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default:  state_d = ST_FETCH;
    endcase

    // Everything still in flight after this cycle, including a same-cycle accept, is stale.
    if (redirect_valid) begin
      fetch_pc_d = target_s;
      resp_pc_d  = target_s;
      drop_d     = outst_d;
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      if (outst_d != '0) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      drop_d = drop_d;
    end

    // Registered request valid, derived from next-cycle credit so it is already correct when seen.
    if ((state_d == ST_FETCH) && (({1'b0, outst_d} + {1'b0, cnt_d}) < DEPTH_C)) begin
      req_valid_d = 1'b1;
    end else begin
      req_valid_d = 1'b0;
    end
  end

  // Control and PC state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Instruction buffer storage; entries clear on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]    <= 32'd0;
        buf_instr_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      buf_pc_q[tail_q]    <= resp_pc_q;
      buf_instr_q[tail_q] <= imem_resp_data;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign if_valid       = (cnt_q != '0);
  assign if_instr       = buf_instr_q[head_q];
  assign if_pc          = buf_pc_q[head_q];

endmodule
